// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one W-bit add/subtract unit between NREQ requesters.
// Each requester owns a one-deep slot. Pending slots are granted round-robin, one per cycle.
module adder_arbiter #(
  parameter int W    = 16,
  parameter int NREQ = 2,
  parameter int PW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_start,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_busy,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      req_y,
  output logic [NREQ-1:0]   ovf_err,
  output logic [15:0]       op_count
);
  localparam int NSLOT = 1 << PW;

  logic [NREQ-1:0]  pending;
  logic [W-1:0]     a_q [NREQ];
  logic [W-1:0]     b_q [NREQ];
  logic [NREQ-1:0]  op_q;
  logic [PW-1:0]    ptr;
  logic [NSLOT-1:0] pend_ext;
  logic             grant_valid;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    ptr_next;
  logic [NREQ-1:0]  gnt_oh;
  logic [NREQ-1:0]  accept;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             sel_op;
  logic [W-1:0]     sum;

  // Round-robin search: first pending slot at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pend_ext = {NSLOT{1'b0}};
    pend_ext[NREQ-1:0] = pending;
    grant_valid = 1'b0;
    grant_idx = {PW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_valid && pend_ext[PW'((int'(ptr) + k) % NREQ)]) begin
        grant_valid = 1'b1;
        grant_idx = PW'((int'(ptr) + k) % NREQ);
      end else begin
        grant_valid = grant_valid;
      end
    end
    if (grant_idx == PW'(NREQ - 1)) begin
      ptr_next = {PW{1'b0}};
    end else begin
      ptr_next = grant_idx + PW'(1'b1);
    end
  end

  // One-hot grant, start acceptance and the operand mux into the single adder.
  always_comb begin
    sel_a = {W{1'b0}};
    sel_b = {W{1'b0}};
    sel_op = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = grant_valid && (grant_idx == PW'(i));
      sel_a = sel_a | (a_q[i] & {W{gnt_oh[i]}});
      sel_b = sel_b | (b_q[i] & {W{gnt_oh[i]}});
      sel_op = sel_op | (op_q[i] & gnt_oh[i]);
    end
    accept = req_start & (~pending | gnt_oh);
    // Subtraction is a + ~b + 1; the carry-in supplies the +1.
    sum = sel_a + (sel_b ^ {W{sel_op}}) + {{(W-1){1'b0}}, sel_op};
  end

  // Slot capture, pending flags and sticky drop errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= {NREQ{1'b0}};
      op_q    <= {NREQ{1'b0}};
      ovf_err <= {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
        a_q[i] <= {W{1'b0}};
        b_q[i] <= {W{1'b0}};
      end
    end else begin
      pending <= (pending & ~gnt_oh) | accept;
      ovf_err <= ovf_err | (req_start & ~accept);
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          a_q[i]  <= req_a[i*W +: W];
          b_q[i]  <= req_b[i*W +: W];
          op_q[i] <= req_op[i];
        end
      end
    end
  end

  // Execute: register the result, ready pulse, pointer advance and op counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= {PW{1'b0}};
      req_ready <= {NREQ{1'b0}};
      req_y     <= {W{1'b0}};
      op_count  <= 16'd0;
    end else begin
      req_ready <= gnt_oh;
      if (grant_valid) begin
        req_y    <= sum;
        ptr      <= ptr_next;
        op_count <= op_count + 16'd1;
      end
    end
  end

  assign req_busy = pending;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed scenarios plus random traffic, checked by a
// per-requester scoreboard that a negedge monitor drains on every ready pulse.
module tb_adder_arbiter;
  localparam int W = 16;
  localparam int NREQ = 2;
  localparam int PW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_start = '0;
  logic [NREQ-1:0]   req_op = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_busy;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      req_y;
  logic [NREQ-1:0]   ovf_err;
  logic [15:0]       op_count;

  typedef struct {
    logic [W-1:0] y;
    int           cyc;
  } exp_t;

  exp_t exp_q [NREQ][$];
  int   issued [NREQ];
  int   popped [NREQ];
  int   done = 0;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerrors = 0;

  adder_arbiter #(.W(W), .NREQ(NREQ), .PW(PW)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_busy(req_busy), .req_ready(req_ready),
    .req_y(req_y), .ovf_err(ovf_err), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nchecks++;
    if (act !== want) begin
      nerrors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_start = '0;
  endtask

  // Drive a start for requester i; the expected result comes from plain arithmetic.
  task automatic arm(input int i, input logic op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit push);
    exp_t e;
    req_start[i] = 1'b1;
    req_op[i] = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    if (push) begin
      e.y = op ? (a - b) : (a + b);
      e.cyc = cyc;
      exp_q[i].push_back(e);
      issued[i]++;
    end
  endtask

  // Monitor: every ready pulse pops the owner's expected result.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        exp_q[i].delete();
        popped[i] = issued[i];
      end
      done = 0;
    end else if (req_ready != '0) begin
      check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          nchecks++;
          if (exp_q[i].size() == 0) begin
            nerrors++;
            $display("FAIL unexpected_ready r%0d: got y=%0h want no pulse", i, req_y);
          end else begin
            exp_t e;
            int lat;
            e = exp_q[i].pop_front();
            check($sformatf("result_r%0d", i), req_y, e.y);
            lat = cyc - e.cyc;
            nchecks++;
            if (lat < 2 || lat > NREQ + 1) begin
              nerrors++;
              $display("FAIL latency_r%0d: got %0d want 2..%0d", i, lat, NREQ + 1);
            end
            popped[i]++;
            done++;
            check("op_count", op_count, 32'(done[15:0]));
          end
        end
      end
    end
  end

  initial begin
    int cnt [NREQ];
    int prev;
    int waited;
    int arm_cyc;
    int p0;
    int stale;
    logic [W-1:0] acc;
    for (int i = 0; i < NREQ; i++) begin
      issued[i] = 0;
      popped[i] = 0;
      cnt[i] = 0;
    end

    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", req_busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_y", req_y, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_count", op_count, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Single add, exact two-cycle latency.
    arm(0, 1'b0, 16'd5, 16'd7, 1'b1);
    tick();
    check("single_busy_e0", req_busy, 2'b01);
    check("single_ready_e0", req_ready, 2'b00);
    tick();
    check("single_ready_e1", req_ready, 2'b01);
    check("single_y", req_y, 16'd12);
    check("single_count", op_count, 16'd1);
    check("single_busy_e1", req_busy, 2'b00);

    // Subtract with borrow, then add with carry out.
    arm(1, 1'b1, 16'd3, 16'd5, 1'b1);
    tick();
    tick();
    check("sub_ready", req_ready, 2'b10);
    check("sub_y", req_y, 16'hFFFE);
    arm(1, 1'b0, 16'hFFFF, 16'd2, 1'b1);
    tick();
    tick();
    check("wrap_y", req_y, 16'h0001);

    // Contention then continuous re-arm: grants must alternate.
    arm(0, 1'b0, 16'd10, 16'd1, 1'b1);
    arm(1, 1'b0, 16'd20, 16'd2, 1'b1);
    tick();
    prev = -1;
    for (int it = 0; it < 21; it++) begin
      if (it == 1) check("contend_first", {req_ready, req_y}, {2'b01, 16'd11});
      if (it == 2) check("contend_second", {req_ready, req_y}, {2'b10, 16'd22});
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          cnt[i]++;
          if (prev >= 0) check("alternate", 32'(i != prev), 32'd1);
          prev = i;
          arm(i, 1'($urandom_range(1, 0)), W'($urandom), W'($urandom), 1'b1);
        end
      end
      tick();
    end
    check("fair_r0", cnt[0], 10);
    check("fair_r1", cnt[1], 10);
    repeat (4) tick();

    // Re-arm on the same edge as the grant: accepted, no error.
    arm(0, 1'b0, 16'd1, 16'd2, 1'b1);
    tick();
    arm(0, 1'b0, 16'd3, 16'd4, 1'b1);
    tick();
    repeat (3) tick();
    check("same_edge_ovf", ovf_err, 2'b00);

    // Back-to-back accumulation y+3.
    acc = '0;
    arm(0, 1'b0, acc, 16'd3, 1'b1);
    arm_cyc = cyc;
    tick();
    for (int n = 0; n < 8; n++) begin
      waited = 0;
      while (!req_ready[0] && waited < 6) begin
        tick();
        waited++;
      end
      if (!req_ready[0]) begin
        nchecks++;
        nerrors++;
        $display("FAIL chain_timeout: got no ready want ready at step %0d", n);
        break;
      end
      check("chain_gap", cyc - arm_cyc, 2);
      acc = acc + 16'd3;
      check("chain_y", req_y, acc);
      if (n < 7) begin
        arm(0, 1'b0, acc, 16'd3, 1'b1);
        arm_cyc = cyc;
      end
      tick();
    end
    repeat (3) tick();
    check("chain_ovf", ovf_err, 2'b00);

    // Overflow: r0 re-starts while pending and r1 holds the grant.
    arm(0, 1'b0, 16'd9, 16'd9, 1'b1);
    repeat (3) tick();
    p0 = popped[0];
    arm(0, 1'b0, 16'd100, 16'd1, 1'b1);
    arm(1, 1'b0, 16'd200, 16'd2, 1'b1);
    tick();
    arm(0, 1'b0, 16'd50, 16'd50, 1'b0);
    tick();
    repeat (3) tick();
    check("ovf_flag", ovf_err, 2'b01);
    check("ovf_single_result", popped[0] - p0, 1);

    // Random traffic: requesters start only when their slot is known idle.
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (issued[i] == popped[i] && $urandom_range(1, 0) == 1)
          arm(i, 1'($urandom_range(1, 0)), W'($urandom), W'($urandom), 1'b1);
      end
      tick();
    end
    repeat (6) tick();
    for (int i = 0; i < NREQ; i++) check($sformatf("drain_r%0d", i), exp_q[i].size(), 0);
    check("random_ovf", ovf_err, 2'b01);

    // Reset mid-operation with both slots pending.
    arm(0, 1'b0, 16'd1, 16'd1, 1'b1);
    arm(1, 1'b0, 16'd2, 16'd2, 1'b1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", req_busy, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_count", op_count, 0);
    check("midrst_ovf", ovf_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    stale = 0;
    repeat (5) begin
      tick();
      if (req_ready != '0) stale++;
    end
    check("no_stale_ready", stale, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one W-bit add/subtract unit between NREQ requesters. Typical requesters are the mult and cubicroot sequencers, which together must stay within the one-summation budget.
- Each requester pulses start with its operands. The arbiter queues at most one operation per requester and grants one operation per cycle, round-robin.
- It returns the result on a shared result bus, with a one-cycle ready pulse to the owning requester.
- It replaces the private summ/subs instances inside the sequencers.

Parameters:
- W, 16, operand and result width.
- NREQ, 2, number of requesters (2..8).
- PW, 3, width of the round-robin pointer; must satisfy 2^PW >= NREQ.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0); release is synchronous to clk.
- req_start  input  NREQ  per-requester one-cycle start pulse.
- req_op  input  NREQ  per-requester operation select: 0 gives a+b, 1 gives a-b.
- req_a  input  NREQ*W  operand a; requester i uses bits [i*W +: W].
- req_b  input  NREQ*W  operand b; requester i uses bits [i*W +: W].
- req_busy  output  NREQ  an operation for requester i is pending.
- req_ready  output  NREQ  one-cycle pulse: req_y holds the result for requester i.
- req_y  output  W  shared result bus; valid only in a cycle where req_ready is non-zero.
- ovf_err  output  NREQ  sticky flag: a start from requester i was dropped.
- op_count  output  16  number of completed operations; wraps at 0xFFFF→0.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0. Pending flags, operand and op registers are cleared. Round-robin pointer is set to 0.
- Reset mid-operation: any queued or in-flight operation is discarded. No req_ready pulse is produced for it after release.
- Capture:
  - On an edge with req_start[i]=1, the requester's a, b and op are latched into its slot and pending[i] is set.
  - The start is accepted if pending[i]=0, or if slot i is granted on this same edge.
  - Otherwise the start is dropped, the slot contents are unchanged, and ovf_err[i] is set. ovf_err clears only on reset.
- req_busy = pending; it is visible one cycle after the capturing edge.
- Arbitration (combinational on registered pending):
  - Grant goes to the first pending slot found searching from ptr upward, wrapping modulo NREQ.
  - At most one grant per cycle.
  - After a grant to slot g, ptr becomes (g+1) mod NREQ. With no grant, ptr holds.
- Execute: on the edge where slot g is granted:
  - req_y <= a_g + b_g (op=0) or a_g - b_g (op=1), modulo 2^W; carry and borrow are discarded.
  - req_ready <= one-hot(g).
  - pending[g] is cleared, unless a new start for g is accepted on the same edge.
  - op_count increments.
- Idle cycle (no grant): req_ready <= 0 and req_y holds its last value.
- Latency: start sampled at edge E0; result and ready are registered at E1, i.e. 2 cycles uncontested. Worst case is NREQ+1 cycles.
- Throughput: one operation per cycle. With all slots continuously re-armed, each requester receives exactly one grant every NREQ cycles (starvation-free).
- Simultaneous starts from several requesters are all captured. They are served in pointer order on consecutive cycles.
- Structure:
  - Exactly one W-bit adder/subtractor is instantiated. The op bit selects b or ~b+1.
  - No other arithmetic is used on the data path; the op_count and ptr increments are control counters.
- Requester contract:
  - Operands are captured at the start edge, so the requester may change req_a and req_b afterwards.
  - A requester waits for its req_ready before issuing a dependent operation.

Test Plan:
- Reset and single op: hold rst=0 for 5 cycles and check all outputs are 0. Release; requester 0 starts with a=5, b=7, op=0. Expect req_ready=2'b01 and req_y=12 exactly 2 cycles after the start, op_count=1, req_busy[0] high for 1 cycle.
- Subtract and wrap: requester 1 issues a=3, b=5, op=1 → req_y=0xFFFE with req_ready=2'b10. Then a=0xFFFF, b=2, op=0 → req_y=0x0001.
- Contention and fairness: both requesters start in the same cycle (r0: 10+1, r1: 20+2). Expect r0 served first (11), r1 next cycle (22). Then re-arm both continuously for 20 cycles; grants must alternate and reach 10 each.
- Overflow: requester 0 starts, then starts again the following cycle while still pending and not granted, which requires r1 to be granted that cycle. Expect the second start dropped, ovf_err[0]=1, and only the first result returned. On the same-edge re-arm case, expect no error.
- Back-to-back chaining: requester 0 re-issues on every req_ready (accumulate y+3, starting at 0, 8 times). Expect results 3, 6, …, 24 with no idle cycle beyond the 2-cycle latency.
- Reset mid-operation: assert rst while both requesters are pending. Expect req_busy, req_ready and op_count all 0 immediately (asynchronously), and no stale ready pulse after release.
